// File: rtl/sub_bytes_serial.sv
// AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per clock.
// S-box bytes come from the GF(2^8) inverse plus the affine map, so no ROM tables are needed.
module sub_bytes_serial #(
    parameter int unsigned LANES = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
        $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StSub, StHold} state_e;

    state_e          state_q;
    logic [127:0]    w_q;
    logic [CW-1:0]   c_q;
    logic            m_q;
    logic [127:0]    w_sub;
    logic            sub_last;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; it maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                r = gf_mul(r, p);
            end
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Forward and inverse share one field inverter; only the affine step moves.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] x;
        logic [7:0] y;
        x = inv ? affine_inv(b) : b;
        y = gf_inv(x);
        return inv ? y : affine_fwd(y);
    endfunction

    always_comb begin
        int idx;
        idx   = 0;
        w_sub = w_q;
        for (int l = 0; l < int'(LANES); l++) begin
            idx = int'(c_q) * int'(LANES) + l;
            w_sub[idx*8 +: 8] = sub_byte(w_q[idx*8 +: 8], m_q);
        end
    end

    assign sub_last = (c_q == CW'(N - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            w_q     <= '0;
            c_q     <= '0;
            m_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        w_q     <= in_state;
                        m_q     <= in_inverse;
                        c_q     <= '0;
                        state_q <= StSub;
                    end
                end
                StSub: begin
                    w_q <= w_sub;
                    if (sub_last) begin
                        c_q     <= '0;
                        state_q <= StHold;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake outputs decode the state only; reset_n masks them while reset is held.
    assign busy      = (state_q != StIdle);
    assign in_ready  = reset_n && (state_q == StIdle);
    assign out_valid = reset_n && (state_q == StHold);
    assign out_state = w_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench: five instances (LANES = 1, 2, 4, 8, 16) share one stimulus stream;
// a negedge monitor checks latency, data, stability and in_ready against queued expectations.
module tb_sub_bytes_serial;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_ready;
    logic [4:0]   ir;
    logic [4:0]   ov;
    logic [4:0]   bz;
    logic [127:0] os [5];

    int nchk;
    int nerr;
    int cyc;
    logic [4:0]   pv;
    logic [127:0] qd [5][$];
    int           qa [5][$];

    localparam logic [127:0] VecIn  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] VecOut = 128'h3052411ee55db4b8f198bfe0ae1127d4;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_serial #(.LANES(1 << g)) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_state  (in_state),
            .in_inverse(in_inverse),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] expv);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: latency on each rising out_valid, data and in_ready every valid cycle.
    initial pv = '0;
    always @(negedge clock) begin
        for (int i = 0; i < 5; i++) begin
            if (ov[i]) begin
                if (qd[i].size() == 0) begin
                    chk(1'b0, $sformatf("spurious out_valid lanes=%0d", 1 << i), 128'(ov[i]), 0);
                end else begin
                    if (!pv[i]) begin
                        chk((cyc - qa[i][0]) == (16 >> i), $sformatf("latency lanes=%0d", 1 << i),
                            128'(cyc - qa[i][0]), 128'(16 >> i));
                    end
                    chk(os[i] == qd[i][0], $sformatf("out_state lanes=%0d", 1 << i),
                        os[i], qd[i][0]);
                    chk(!ir[i], $sformatf("in_ready in hold lanes=%0d", 1 << i),
                        128'(ir[i]), 0);
                    if (out_ready) begin
                        void'(qd[i].pop_front());
                        void'(qa[i].pop_front());
                    end
                end
            end
        end
        pv = ov;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ir != 5'h1f && n < 100) begin
            step();
            n++;
        end
        chk(ir == 5'h1f, "in_ready timeout", 128'(ir), 128'h1f);
    endtask

    task automatic issue(input logic [127:0] d, input logic inv, input logic [127:0] e,
                         input bit push);
        wait_ready();
        in_valid   = 1'b1;
        in_state   = d;
        in_inverse = inv;
        if (push) begin
            for (int i = 0; i < 5; i++) begin
                qd[i].push_back(e);
                qa[i].push_back(cyc + 1);
            end
        end
        step();
        // Scramble inputs while busy; they must be ignored.
        in_valid   = 1'b0;
        in_state   = ~d;
        in_inverse = ~inv;
    endtask

    task automatic drain();
        int n;
        int left;
        n    = 0;
        left = 1;
        while (left != 0 && n < 200) begin
            left = 0;
            for (int i = 0; i < 5; i++) left += qd[i].size();
            if (left != 0) step();
            n++;
        end
        chk(left == 0, "drain timeout", 128'(left), 0);
    endtask

    initial begin
        nchk       = 0;
        nerr       = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_state   = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        chk(ir == 5'h00, "in_ready in reset", 128'(ir), 0);
        chk(ov == 5'h00, "out_valid in reset", 128'(ov), 0);
        chk(bz == 5'h00, "busy after reset", 128'(bz), 0);
        for (int i = 0; i < 5; i++) chk(os[i] == '0, "out_state after reset", os[i], 0);
        reset_n = 1'b1;
        step();
        chk(ir == 5'h1f, "in_ready after reset", 128'(ir), 128'h1f);

        // FIPS-197 round-1 vector, forward then inverse.
        issue(VecIn, 1'b0, VecOut, 1'b1);
        chk(bz == 5'h1f, "busy during sub", 128'(bz), 128'h1f);
        drain();
        issue(VecOut, 1'b1, VecIn, 1'b1);
        drain();

        // Uniform-byte table points, issued back to back.
        issue({16{8'h00}}, 1'b0, {16{8'h63}}, 1'b1);
        issue({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        issue({16{8'h63}}, 1'b0, {16{8'hfb}}, 1'b1);
        issue({16{8'hff}}, 1'b0, {16{8'h16}}, 1'b1);
        issue({16{8'h63}}, 1'b1, {16{8'h00}}, 1'b1);
        issue({16{8'hed}}, 1'b1, {16{8'h53}}, 1'b1);
        drain();

        // Backpressure: hold results for 10 cycles with inputs toggling.
        out_ready = 1'b0;
        issue(VecIn, 1'b0, VecOut, 1'b1);
        begin
            int n;
            n = 0;
            while (ov != 5'h1f && n < 40) begin
                step();
                n++;
            end
        end
        chk(ov == 5'h1f, "all reach hold", 128'(ov), 128'h1f);
        for (int k = 0; k < 10; k++) begin
            in_state   = {$urandom, $urandom, $urandom, $urandom};
            in_inverse = ~in_inverse;
            step();
            chk(ov == 5'h1f, "out_valid held", 128'(ov), 128'h1f);
            chk(ir == 5'h00, "in_ready held low", 128'(ir), 0);
        end
        out_ready = 1'b1;
        step();
        chk(ir == 5'h1f, "in_ready after release", 128'(ir), 128'h1f);
        chk(ov == 5'h00, "out_valid after release", 128'(ov), 0);
        drain();

        // Reset during the second SUB cycle discards the block.
        issue(VecIn, 1'b0, VecOut, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        chk(ir == 5'h00, "in_ready forced low", 128'(ir), 0);
        chk(ov == 5'h00, "out_valid forced low", 128'(ov), 0);
        step();
        reset_n = 1'b1;
        step();
        chk(ir == 5'h1f, "in_ready after mid reset", 128'(ir), 128'h1f);
        chk(bz == 5'h00, "busy after mid reset", 128'(bz), 0);
        repeat (20) step();
        issue(VecIn, 1'b0, VecOut, 1'b1);
        drain();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got t=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub_bytes_serial.md
SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 Parameter: LANES, 4, S-box lanes per cycle; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream (AddRoundKey) presents a state.
REQ-005 Port: in_ready  output  1  block accepts a state this cycle.
REQ-006 Port: in_state  input  128 (state_t)  byte i = bits [8i+7:8i], FIPS-197 byte i.
REQ-007 Port: in_inverse  input  1  0 = forward S-box, 1 = inverse S-box; sampled with in_state.
REQ-008 Port: out_valid  output  1  out_state holds a complete result for ShiftRows / ShiftRowsInverse.
REQ-009 Port: out_ready  input  1  downstream consumes the result.
REQ-010 Port: out_state  output  128 (state_t)  substituted state, same byte mapping as in_state.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SUB and HOLD.
REQ-013 Constant N = 16/LANES cycles per block.
REQ-014 Working register W: 128 bits. Lane counter C: ceil(log2(N)) bits, minimum 1 bit. Latched mode bit M.
REQ-015 IDLE behaviour:
- in_ready = 1.
- On in_valid=1 at a rising edge: W <= in_state, M <= in_inverse, C <= 0, next state SUB.
REQ-016 SUB behaviour:
- in_ready = 0.
- Each edge replaces bytes C*LANES .. C*LANES+LANES-1 of W with S(byte) when M=0, or InvS(byte) when M=1.
- S and InvS are the FIPS-197 tables.
REQ-017 In SUB, C SHALL increment each edge; at the edge where C = N-1, next state is HOLD.
- C wraps to 0 at that edge.
- With LANES=16, SUB lasts exactly one cycle.
REQ-018 Latency: if the input handshake occurs at edge k, out_valid SHALL be 1 from edge k+N onward.
REQ-019 HOLD behaviour:
- out_valid = 1 and out_state = W, held stable.
- W and M SHALL NOT change while out_ready = 0.
- in_ready = 0.
REQ-020 In HOLD, on out_ready=1 at an edge, next state is IDLE.
- No new input is accepted in that same cycle.
- Maximum throughput is one block per N+2 cycles.
REQ-021 out_valid SHALL be 0 in IDLE and SUB.
- out_state SHALL equal W in all states.
- out_state content is meaningful only when out_valid = 1.
REQ-022 Changes to in_state and in_inverse while in_ready = 0 SHALL have no effect.
REQ-023 out_valid SHALL NOT drop until out_ready is seen (valid/ready rule).
REQ-024 busy SHALL be combinational from the FSM state; in_ready and out_valid SHALL depend only on the FSM state and reset_n, with no combinational path from any input.

Reset
REQ-025 At a rising edge with reset_n = 0: state <= IDLE, W <= 0, C <= 0, M <= 0.
REQ-026 While reset_n = 0, in_ready and out_valid SHALL be forced to 0.
- After the first edge with reset_n = 1, in_ready = 1.
REQ-027 Reset asserted during SUB or HOLD SHALL discard the block in progress; no partial result is emitted.

Verification
REQ-028 Forward FIPS-197 vector, LANES=4:
- Stimulus: in_state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, in_inverse=0, out_ready=1.
- Response: out_valid rises 4 edges after acceptance; out_state = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
REQ-029 Inverse vector: feed the REQ-028 output with in_inverse=1 -> out_state equals the original REQ-028 input.
REQ-030 Table sweep, LANES=16:
- Feed all-00, all-53 and all-63 states in forward mode -> 63.., ed.., fb.. respectively, each after 1 SUB cycle.
- Feed all-63 in inverse mode -> all-00.
REQ-031 Backpressure:
- Hold out_ready=0 for 10 cycles in HOLD; toggle in_state and in_inverse throughout.
- Response: out_valid stays 1, out_state stays constant, in_ready stays 0.
- Then pulse out_ready: state IDLE next cycle, in_ready=1.
REQ-032 Reset mid-operation:
- Assert reset_n=0 for one edge at SUB cycle 2.
- Response: out_valid never rises, in_ready=1 after release.
- The next block produces a correct result.
REQ-033 Parameter sweep: LANES in {1, 2, 8} with the REQ-028 vector -> identical output, with out_valid latency 16, 8 and 2 edges respectively.
